// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs field-level RV32I requests into words and loads them into IMEM
// Optional trailing NOP fill of unused IMEM words when ENCODER_NOP_FILL_EN is defined.
module instr_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   instr_count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);
`ifdef ENCODER_NOP_FILL_EN
    localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WR,
`ifdef ENCODER_NOP_FILL_EN
        S_FILL,
`endif
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  f_type;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [2:0]  f_funct3;
    logic [6:0]  f_funct7;
    logic [31:0] f_imm;
    logic        f_last;

    logic [31:0] enc_word;
    logic        imm_ok, type_ok, full, enc_err;
    logic [1:0]  enc_code;
    logic        at_end;

    // Field packing and range check from the registered request.
    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b1;
        type_ok  = 1'b1;
        case (f_type)
            4'd0, 4'd1: begin
                enc_word = {f_imm[31:12], f_rd, (f_type == 4'd0) ? 7'b0110111 : 7'b0010111};
                imm_ok   = (f_imm[11:0] == 12'd0);
            end
            4'd2: begin
                enc_word = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, 7'b1101111};
                imm_ok   = (f_imm[31:20] == {12{f_imm[20]}}) && !f_imm[0];
            end
            4'd3: begin
                enc_word = {f_imm[11:0], f_rs1, 3'b000, f_rd, 7'b1100111};
                imm_ok   = (f_imm[31:11] == {21{f_imm[11]}});
            end
            4'd4: begin
                enc_word = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_funct3, f_imm[4:1], f_imm[11], 7'b1100011};
                imm_ok   = (f_imm[31:12] == {20{f_imm[12]}}) && !f_imm[0];
            end
            4'd5: begin
                enc_word = {f_imm[11:0], f_rs1, f_funct3, f_rd, 7'b0000011};
                imm_ok   = (f_imm[31:11] == {21{f_imm[11]}});
            end
            4'd6: begin
                enc_word = {f_imm[11:5], f_rs2, f_rs1, f_funct3, f_imm[4:0], 7'b0100011};
                imm_ok   = (f_imm[31:11] == {21{f_imm[11]}});
            end
            4'd7: begin
                if (f_funct3 == 3'b001 || f_funct3 == 3'b101) begin
                    enc_word = {f_funct7, f_imm[4:0], f_rs1, f_funct3, f_rd, 7'b0010011};
                    imm_ok   = (f_imm[31:5] == 27'd0);
                end else begin
                    enc_word = {f_imm[11:0], f_rs1, f_funct3, f_rd, 7'b0010011};
                    imm_ok   = (f_imm[31:11] == {21{f_imm[11]}});
                end
            end
            4'd8: enc_word = {f_funct7, f_rs2, f_rs1, f_funct3, f_rd, 7'b0110011};
            default: type_ok = 1'b0;
        endcase
    end

    // Error priority when several apply: bad type, then memory full, then immediate range.
    assign full     = (instr_count == FULL_CNT);
    assign enc_err  = !type_ok || full || !imm_ok;
    assign enc_code = !type_ok ? 2'b10 : (full ? 2'b11 : 2'b01);
    assign at_end   = (imem_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        imem_we   = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = !done;
                if (req_valid && !done) state_nxt = S_ENC;
            end
            S_ENC: state_nxt = enc_err ? S_IDLE : S_WR;
            S_WR: begin
                imem_we = 1'b1;
                if (imem_ack) begin
`ifdef ENCODER_NOP_FILL_EN
                    if (f_last) state_nxt = at_end ? S_DONE : S_FILL;
`else
                    if (f_last) state_nxt = S_DONE;
`endif
                    else        state_nxt = S_IDLE;
                end
            end
`ifdef ENCODER_NOP_FILL_EN
            S_FILL: begin
                imem_we = 1'b1;
                if (imem_ack && at_end) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                busy = 1'b0;
                if (clear) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr   <= '0;
            imem_wdata  <= '0;
            instr_count <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            f_type      <= '0;
            f_rd        <= '0;
            f_rs1       <= '0;
            f_rs2       <= '0;
            f_funct3    <= '0;
            f_funct7    <= '0;
            f_imm       <= '0;
            f_last      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (clear) begin
                        imem_addr   <= '0;
                        instr_count <= '0;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        err_code    <= 2'b00;
                    end
                    if (state == S_IDLE && req_valid && !done) begin
                        f_type   <= req_type;
                        f_rd     <= req_rd;
                        f_rs1    <= req_rs1;
                        f_rs2    <= req_rs2;
                        f_funct3 <= req_funct3;
                        f_funct7 <= req_funct7;
                        f_imm    <= req_imm;
                        f_last   <= req_last;
                    end
                end
                S_ENC: begin
                    if (enc_err) begin
                        if (!err) begin
                            err      <= 1'b1;
                            err_code <= enc_code;
                        end
                    end else begin
                        imem_wdata <= enc_word;
                    end
                end
                S_WR: begin
                    if (imem_ack) begin
                        // Address saturates at the last word so it never wraps to 0.
                        if (!at_end) imem_addr <= imem_addr + 1'b1;
                        instr_count <= instr_count + 1'b1;
`ifdef ENCODER_NOP_FILL_EN
                        if (f_last) begin
                            if (at_end) done <= 1'b1;
                            else        imem_wdata <= NOP_WORD;
                        end
`else
                        if (f_last) done <= 1'b1;
`endif
                    end
                end
`ifdef ENCODER_NOP_FILL_EN
                S_FILL: begin
                    if (imem_ack) begin
                        if (at_end) done <= 1'b1;
                        else        imem_addr <= imem_addr + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized bench for instr_encoder_loader against a field-level encoding model
module tb_instr_encoder_loader;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk = 0;
    logic              rst, clear, req_valid, req_ready, req_last;
    logic [3:0]        req_type;
    logic [4:0]        req_rd, req_rs1, req_rs2;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [31:0]       req_imm;
    logic              imem_we, imem_ack, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   instr_count;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm), .req_last(req_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ack_mode = 0, wait_ctr = 0;
    int m_count = 0, m_code = 0, m_done = 0, m_err = 0;
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] wr_mem[0:DEPTH-1];
    int wr_total = 0, cur_we_cyc = 0, last_we_cyc = 0;
    logic held = 0;
    logic [31:0] h_addr, h_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Encoding straight from the RV32I field layouts, using plain arithmetic on the byte offset.
    function automatic int model_enc(input int t, input logic [31:0] rd, rs1, rs2, f3, f7,
                                     input logic [31:0] imm, output logic [31:0] w);
        int s;
        bit ok;
        s = $signed(imm);
        w = 0;
        ok = 1;
        case (t)
            0, 1: begin
                w = (imm & 32'hFFFFF000) | (rd << 7) | ((t == 0) ? 32'h37 : 32'h17);
                ok = (imm % 4096) == 0;
            end
            2: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
                ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
            end
            3, 5: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7)
                  | ((t == 3) ? 32'h67 : ((f3 << 12) | 32'h03));
                ok = (s >= -2048) && (s <= 2047);
            end
            4: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                  | (f3 << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            end
            6: begin
                w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                  | ((imm & 31) << 7) | 32'h23;
                ok = (s >= -2048) && (s <= 2047);
            end
            7: begin
                if (f3 == 1 || f3 == 5) begin
                    w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                    ok = imm < 32;
                end else begin
                    w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                    ok = (s >= -2048) && (s <= 2047);
                end
            end
            8: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            default: return 2;
        endcase
        return ok ? 0 : 1;
    endfunction

    function automatic logic [31:0] rand_imm(input int t, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        if ($urandom % 4 == 0) return r;
        case (t)
            0, 1: return r & 32'hFFFFF000;
            2: return {{11{r[20]}}, r[20:1], 1'b0};
            4: return {{19{r[12]}}, r[12:1], 1'b0};
            7: if (f3 == 3'd1 || f3 == 3'd5) return {27'd0, r[4:0]};
               else return {{20{r[11]}}, r[11:0]};
            default: return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    // Memory acknowledge: always, random, or withheld for five write cycles.
    initial begin
        imem_ack = 0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0: imem_ack = 1;
                1: imem_ack = ($urandom % 3) == 0;
                default: begin
                    if (!imem_we) begin
                        wait_ctr = 0;
                        imem_ack = 0;
                    end else begin
                        imem_ack = (wait_ctr == 5);
                        wait_ctr++;
                    end
                end
            endcase
        end
    end

    // Every write cycle is checked against the model's expected write stream.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                cur_we_cyc++;
                if (held) begin
                    check("hold_addr", 32'(imem_addr), h_addr);
                    check("hold_wdata", imem_wdata, h_data);
                end
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", 32'(imem_addr), 32'hFFFFFFFF);
                end else begin
                    check("wr_addr", 32'(imem_addr), exp_addr[0]);
                    check("wr_data", imem_wdata, exp_data[0]);
                end
                if (imem_ack) begin
                    wr_mem[imem_addr] = imem_wdata;
                    if (exp_addr.size() != 0) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                    wr_total++;
                    last_we_cyc = cur_we_cyc;
                    cur_we_cyc = 0;
                    held = 0;
                end else begin
                    held = 1;
                    h_addr = 32'(imem_addr);
                    h_data = imem_wdata;
                end
            end else begin
                held = 0;
                cur_we_cyc = 0;
            end
        end
    end

    task automatic check_status();
        check("count", 32'(instr_count), 32'(m_count));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
        check("done", 32'(done), 32'(m_done));
        check("req_ready", 32'(req_ready), (m_done != 0) ? 32'd0 : 32'd1);
    endtask

    task automatic do_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
        m_count = 0; m_done = 0; m_err = 0; m_code = 0;
        check_status();
    endtask

    task automatic send(input int t, input int rd, rs1, rs2, f3, f7, input logic [31:0] imm, input bit last);
        int n, code;
        logic [31:0] w;
        bit writes;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_type = 4'(t); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2);
        req_funct3 = 3'(f3); req_funct7 = 7'(f7); req_imm = imm; req_last = last;
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        code = model_enc(t, 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm, w);
        if (code != 2 && m_count == DEPTH) code = 3;
        writes = (code == 0);
        if (writes) begin
            exp_addr.push_back(32'(m_count));
            exp_data.push_back(w);
            m_count++;
            if (last) begin
`ifdef ENCODER_NOP_FILL_EN
                for (int a = m_count; a < DEPTH; a++) begin
                    exp_addr.push_back(32'(a));
                    exp_data.push_back(32'h00000013);
                end
`endif
                m_done = 1;
            end
        end else if (!m_err) begin
            m_err = 1;
            m_code = code;
        end
        @(negedge clk);
        check("enc_no_we", 32'(imem_we), 32'd0);
        check("enc_busy", 32'(busy), 32'd1);
        @(negedge clk);
        if (writes) check("latency_we", 32'(imem_we), 32'd1);
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
        check_status();
    endtask

    initial begin
        int t, f3, w0;
        rst = 1; clear = 0; req_valid = 0; req_type = 0; req_rd = 0; req_rs1 = 0; req_rs2 = 0;
        req_funct3 = 0; req_funct7 = 0; req_imm = 0; req_last = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check_status();

        send(7, 1, 0, 0, 0, 0, 32'd5, 0);
        check("addi_word", wr_mem[0], 32'h00500093);
        do_clear();
        send(0, 2, 0, 0, 0, 0, 32'h12345000, 0);
        send(8, 3, 1, 2, 0, 0, 32'd0, 0);
        send(4, 0, 1, 2, 0, 0, -32'sd4, 1);
        check("lui_word", wr_mem[0], 32'h12345137);
        check("add_word", wr_mem[1], 32'h002081B3);
        check("beq_word", wr_mem[2], 32'hFE208EE3);
        check("beq_done", 32'(done), 1);
        check("beq_ready", 32'(req_ready), 0);
        do_clear();

        w0 = wr_total;
        send(2, 1, 0, 0, 0, 0, 32'd3, 0);
        send(12, 1, 0, 0, 0, 0, 32'd0, 0);
        check("err_first_code", 32'(err_code), 32'd1);
        check("err_no_write", 32'(wr_total), 32'(w0));
        do_clear();

        ack_mode = 2;
        send(7, 4, 4, 0, 0, 0, 32'd7, 0);
        check("ack_wait_cycles", 32'(last_we_cyc), 32'd6);
        check("ack_wait_count", 32'(instr_count), 32'd1);
        ack_mode = 0;
        do_clear();

        w0 = wr_total;
        for (int i = 0; i < 5; i++) send(7, 1, 0, 0, 0, 0, 32'(i), 0);
        check("full_writes", 32'(wr_total - w0), 32'd4);
        check("full_code", 32'(err_code), 32'd3);
        do_clear();
        check("clear_count", 32'(instr_count), 32'd0);

        ack_mode = 1;
        for (int i = 0; i < 200; i++) begin
            if (m_done != 0 || ($urandom % 20) == 0) do_clear();
            t = ($urandom % 20 == 19) ? int'($urandom_range(9, 15)) : int'($urandom % 9);
            f3 = int'($urandom % 8);
            send(t, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), f3,
                 int'($urandom % 128), rand_imm(t, 3'(f3)), ($urandom % 8) == 0);
        end
        check("exp_queue_drained", 32'(exp_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the mini_cpu instruction decoder. Accepts field-level instruction requests (class, register addresses, funct3/funct7, full 32-bit immediate) over a valid/ready handshake. Packs each request into an RV32I word using the I/S/B/U/J immediate layouts and range-checks the immediate. Writes accepted words sequentially into instruction memory through a stallable write port. Used by the bench and by the boot path to load programs into IMEM.

Parameters:
ADDR_W, 10, IMEM word-address width
DEPTH, 1024, number of IMEM words; must be ≤ 2^ADDR_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous: address to 0, clears done/err/count
req_valid  in  1  request valid
req_ready  out  1  encoder can accept a request
req_type  in  4  0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 ALUI,8 ALUR; others invalid
req_rd / req_rs1 / req_rs2  in  5 each  register addresses
req_funct3  in  3  funct3
req_funct7  in  7  funct7 (ALUR; ALUI shifts)
req_imm  in  32  sign-extended immediate (byte offset for branch/jump)
req_last  in  1  final instruction of program
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
imem_ack  in  1  memory accepted write
busy  out  1  FSM not IDLE/DONE
done  out  1  sticky: last word written
err  out  1  sticky error
err_code  out  2  first error: 01 imm range, 10 bad type, 11 memory full
instr_count  out  ADDR_W+1  words written

Behaviour:
- Reset: FSM=IDLE. imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, err_code=0, instr_count=0, busy=0, req_ready=1.
- FSM: IDLE -> ENC -> WR -> IDLE|DONE.
  - IDLE: req_ready=1 when !done. Handshake when req_valid&&req_ready: fields registered, go to ENC.
  - ENC (1 cycle): opcode select, field packing, range check.
    - On error: set err and capture err_code only if err was 0; no write; count and address unchanged; return to IDLE.
    - Otherwise go to WR.
  - WR: imem_we=1 with addr/wdata held stable until imem_ack.
    - On ack: address+1, count+1; go to DONE if last was set, else IDLE.
    - Latency from accept to earliest write: 2 cycles.
  - DONE: req_ready=0 until clear.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (funct3 forced 000), BRANCH 1100011, LOAD 0000011, STORE 0100011, ALUI 0010011, ALUR 0110011.
- Unused fields are 0: rs1/rs2 for U/J, rs2 for I, rd for S/B.
- Range rules:
  - I/S: req_imm[31:11] all equal (signed 12-bit).
  - B: signed 13-bit and imm[0]=0.
  - J: signed 21-bit and imm[0]=0.
  - U: imm[11:0]=0.
  - ALUI with funct3 001/101: req_imm[31:5]=0; inst[31:25]=req_funct7.
- Full: an accepted request when instr_count==DEPTH yields err_code 11 and no write. Address never wraps.
- clear: honoured only in IDLE/DONE; ignored otherwise.
- rst mid-WR: imem_we drops immediately (async).
- err does not block further requests.

Optional Feature:
ENCODER_NOP_FILL_EN.
- Defined: after the last word is written, FSM enters FILL. It writes NOP 0x00000013 to every remaining address up to DEPTH-1, one ack per word, then enters DONE. busy=1 and req_ready=0 during FILL. instr_count counts program words only.
- Undefined: FILL state absent; the last word goes directly to DONE.

Test Plan:
- ADDI x1,x0,5 (type 7, rd 1, imm 5), ack same cycle -> imem_addr 0, wdata 0x00500093; count 1.
- LUI x2 imm 0x12345000, then ADD x3,x1,x2 (type 8) -> words 0x12345137, 0x002081B3 at addr 0,1.
- BEQ x1,x2 imm -4 with last=1 -> wdata 0xFE208EE3; done=1; req_ready=0.
- JAL rd 1 imm 3 (odd) -> err=1, err_code 01, no imem_we. A following bad type 12 leaves err_code 01.
- imem_ack withheld 5 cycles -> imem_we/addr/wdata stable; single count increment.
- DEPTH=4: five requests -> 4 writes, fifth gives err_code 11. clear -> count 0, done/err 0.
